// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the 4-bit feedback register and its arbiter.
// Register vectors are held as {Q1,Q2,Q3,Q4}, the same order as rnd_data.
package lfsr_pkg;

    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] STUCK_ZERO = 4'b0000;
    localparam logic [LFSR_W-1:0] STUCK_ONES = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Q1<=Q2^Q3^Q4, Q2<=Q1, Q3<=Q2, Q4<=Q3
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[2] ^ q[1] ^ q[0], q[3:1]};
    endfunction

    // Seed bit i drives stage Q(i+1), so the register view is the seed reversed.
    function automatic logic [LFSR_W-1:0] seed_to_q(input logic [LFSR_W-1:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

endpackage

// File: rtl/lfsr4_core.sv
// Four-stage feedback shift register with seed load; load beats step.
module lfsr4_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_SEED = 4'b0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= seed_to_q(RST_SEED);
        end else if (load) begin
            q <= seed_to_q(load_val);
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin sharing of one 4-bit feedback register between NUM_REQ consumers,
// with run-time reseeding and recovery from the two stuck states.
module lfsr_rng_arbiter
    import lfsr_pkg::*;
#(
    parameter int                NUM_REQ        = 2,
    parameter int                STEPS_PER_WORD = 1,
    parameter logic [LFSR_W-1:0] RST_SEED       = 4'b0001,
    parameter logic [LFSR_W-1:0] RECOVERY_SEED  = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LFSR_W-1:0]  cfg_seed,
    input  logic               cfg_load,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    output logic [LFSR_W-1:0]  rnd_data,
    output logic               busy,
    output logic               stuck_err,
    input  logic               err_clr
);

    localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [3:0]       LAST_STEP = 4'(STEPS_PER_WORD - 1);

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [3:0]        step_cnt;
    int                cand;

    logic [LFSR_W-1:0] q;
    logic [LFSR_W-1:0] q_next;
    logic              step_stuck;
    logic              seed_bad;
    logic              core_load;
    logic              core_step;
    logic [LFSR_W-1:0] core_load_val;
    logic              gnt_req_live;

    lfsr4_core #(
        .RST_SEED (RST_SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_load_val),
        .step     (core_step),
        .q        (q)
    );

    // First active requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!pick_found && req[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign q_next       = lfsr_next(q);
    assign step_stuck   = (q_next == q);
    assign seed_bad     = (cfg_seed == STUCK_ZERO) || (cfg_seed == STUCK_ONES);
    assign gnt_req_live = req[gnt_idx];

    always_comb begin
        core_load     = 1'b0;
        core_step     = 1'b0;
        core_load_val = cfg_seed;
        if (cfg_load) begin
            core_load     = 1'b1;
            core_load_val = seed_bad ? RECOVERY_SEED : cfg_seed;
        end else if (state == STEP) begin
            if (step_stuck) begin
                core_load     = 1'b1;
                core_load_val = RECOVERY_SEED;
            end else begin
                core_step = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            gnt       <= '0;
            step_cnt  <= '0;
            stuck_err <= 1'b0;
        end else begin
            if ((cfg_load && seed_bad) || (!cfg_load && state == STEP && step_stuck)) begin
                stuck_err <= 1'b1;
            end else if (err_clr) begin
                stuck_err <= 1'b0;
            end

            if (cfg_load) begin
                state <= IDLE;
                gnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable && pick_found) begin
                            gnt      <= NUM_REQ'(1) << pick_idx;
                            gnt_idx  <= pick_idx;
                            step_cnt <= '0;
                            state    <= STEP;
                        end
                    end
                    STEP: begin
                        // A dropped request abandons the grant; the register step still lands.
                        if (!gnt_req_live) begin
                            gnt   <= '0;
                            state <= IDLE;
                        end else begin
                            step_cnt <= step_cnt + 4'd1;
                            if (step_cnt == LAST_STEP) state <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (!gnt_req_live) begin
                            gnt   <= '0;
                            state <= IDLE;
                        end else if (rnd_ready) begin
                            gnt    <= '0;
                            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rnd_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign rnd_data  = q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Scoreboard bench for lfsr_rng_arbiter: stimulus queues expected transfers,
// a monitor pops and compares each accepted word.
module tb_lfsr_rng_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cfg_seed = 4'b0000;
    logic       cfg_load = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       rnd_valid;
    logic       rnd_ready = 1'b0;
    logic [3:0] rnd_data;
    logic       busy;
    logic       stuck_err;
    logic       err_clr = 1'b0;

    typedef struct {
        logic [3:0] data;
        logic [1:0] gnt;
        int         gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_xfer = 0;

    lfsr_rng_arbiter #(
        .NUM_REQ        (2),
        .STEPS_PER_WORD (1),
        .RST_SEED       (4'b0001),
        .RECOVERY_SEED  (4'b0001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_seed  (cfg_seed),
        .cfg_load  (cfg_load),
        .enable    (enable),
        .req       (req),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_data  (rnd_data),
        .busy      (busy),
        .stuck_err (stuck_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] g, input int gap);
        exp_t x;
        x.data = d;
        x.gnt  = g;
        x.gap  = gap;
        sb.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rnd_valid) break;
        end
        chk(name, rnd_valid, 1);
    endtask

    // Monitor: an accepted word is valid & ready without a coinciding reseed.
    always @(negedge clk) begin
        if (rst && rnd_valid && rnd_ready && !cfg_load) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer", {28'd0, rnd_data}, 32'hffff_ffff);
            end else begin
                e = sb.pop_front();
                chk("xfer_data", rnd_data, e.data);
                chk("xfer_gnt", gnt, e.gnt);
                if (e.gap > 0) chk("xfer_gap", cyc - last_xfer, e.gap);
            end
            last_xfer = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_valid", rnd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stuck", stuck_err, 0);
        chk("rst_data", rnd_data, 4'b1000);

        // Single requester, sequence of 8 words
        rst = 1'b1;
        enable = 1'b1;
        rnd_ready = 1'b1;
        push(4'b0100, 2'b01, 0);
        push(4'b1010, 2'b01, 3);
        push(4'b1101, 2'b01, 3);
        push(4'b0110, 2'b01, 3);
        push(4'b0011, 2'b01, 3);
        push(4'b0001, 2'b01, 3);
        push(4'b1000, 2'b01, 3);
        push(4'b0100, 2'b01, 3);
        req = 2'b01;
        wait_drain("seq_drain", 100);
        req = 2'b00;

        // Round-robin from a fresh reset
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(4'b0100, 2'b01, 0);
        push(4'b1010, 2'b10, 3);
        push(4'b1101, 2'b01, 3);
        push(4'b0110, 2'b10, 3);
        req = 2'b11;
        wait_drain("rr_drain", 60);
        req = 2'b00;

        // Backpressure: word, grant and register held while not ready
        rnd_ready = 1'b0;
        req = 2'b01;
        wait_valid("bp_wait", 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rnd_valid, 1);
            chk("bp_data", rnd_data, 4'b0011);
            chk("bp_gnt", gnt, 2'b01);
        end
        @(posedge clk);
        #1;
        push(4'b0011, 2'b01, 0);
        rnd_ready = 1'b1;
        wait_drain("bp_drain", 20);
        req = 2'b00;

        // enable low blocks new grants
        enable = 1'b0;
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_busy", busy, 0);
            chk("en_gnt", gnt, 2'b00);
        end
        @(posedge clk);
        #1;
        req = 2'b00;
        enable = 1'b1;

        // Stuck seeds
        cfg_seed = 4'b1111;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        @(negedge clk);
        chk("stuck1_data", rnd_data, 4'b1000);
        chk("stuck1_err", stuck_err, 1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_err", stuck_err, 0);
        @(posedge clk);
        #1;
        cfg_seed = 4'b0000;
        cfg_load = 1'b1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        chk("stuck0_data", rnd_data, 4'b1000);
        chk("stuck0_err_set_wins", stuck_err, 1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        cfg_seed = 4'b0010;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        @(negedge clk);
        chk("load_data", rnd_data, 4'b0100);
        chk("load_err", stuck_err, 0);

        // Abort during STEP; pointer stays on requester 1
        @(posedge clk);
        #1;
        req = 2'b10;
        @(posedge clk);
        #1;
        req = 2'b00;
        @(negedge clk);
        chk("abort_gnt_before", gnt, 2'b10);
        chk("abort_busy_before", busy, 1);
        @(negedge clk);
        chk("abort_gnt", gnt, 2'b00);
        chk("abort_busy", busy, 0);
        chk("abort_data", rnd_data, 4'b1010);
        @(posedge clk);
        #1;
        push(4'b1101, 2'b10, 0);
        req = 2'b11;
        wait_drain("abort_drain", 20);
        req = 2'b00;

        // Reseed coinciding with a transfer: reseed wins
        rnd_ready = 1'b0;
        req = 2'b01;
        wait_valid("ld_wait", 20);
        rnd_ready = 1'b1;
        cfg_seed = 4'b0100;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk("ldx_busy", busy, 0);
        chk("ldx_valid", rnd_valid, 0);
        chk("ldx_gnt", gnt, 2'b00);
        chk("ldx_data", rnd_data, 4'b0010);
        @(posedge clk);
        #1;
        push(4'b1001, 2'b01, 0);
        req = 2'b11;
        wait_drain("ldx_drain", 20);
        req = 2'b00;

        // Async reset in the middle of STEP
        cfg_seed = 4'b1111;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        push(4'b0100, 2'b01, 0);
        req = 2'b01;
        wait_drain("ar_drain", 20);
        @(posedge clk);
        #1;
        chk("ar_busy_before", busy, 1);
        chk("ar_stuck_before", stuck_err, 1);
        rst = 1'b0;
        #1;
        chk("ar_gnt", gnt, 2'b00);
        chk("ar_valid", rnd_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_stuck", stuck_err, 0);
        chk("ar_data", rnd_data, 4'b1000);
        req = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
